// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable data width, parity and stop bits.
// Synchronised input, 3-sample majority voting, start-glitch rejection and error flags.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 br_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   rx_meta_q, rx_s_q;
    logic [1:0]             win_q, win_d;
    logic [2:0]             window;
    logic                   smp;

    // The window is the two previous tick samples plus the sample taken on this tick.
    assign window = {win_q, rx_s_q};
    assign smp    = (window[0] & window[1]) | (window[0] & window[2]) | (window[1] & window[2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            win_q        <= 2'b11;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            win_q        <= win_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        win_d        = win_q;
        if (br_tick) win_d = {win_q[0], rx_s_q};

        case (state_q)
            IDLE: begin
                // High on the previous tick and low now: a held-low line never retriggers.
                if (br_tick && win_q[0] && !rx_s_q) begin
                    state_d = START;
                    tick_d  = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (br_tick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = smp ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (br_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        for (int i = 0; i < DATA_BITS; i++)
                            if (bit_q == BW'(i)) shift_d[i] = smp;
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            PARITY: begin
                if (br_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        perr_d  = (^shift_q) ^ smp ^ 1'(PARITY_ODD);
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            STOP: begin
                if (br_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (!smp) ferr_d = 1'b1;
                        if (bit_q == STOP_LAST) begin
                            bit_d        = '0;
                            state_d      = DONE;
                            rx_data_d    = shift_q;
                            parity_err_d = perr_q;
                            frame_err_d  = ferr_q | ~smp;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rx_data    = rx_data_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_done    = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8N1, even-parity and 7-bit/2-stop instances.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       br_tick = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic [7:0] rx_data_a, rx_data_b;
    logic [6:0] rx_data_c;
    logic       rx_done_a, rx_done_b, rx_done_c;
    logic       parity_err_a, parity_err_b, parity_err_c;
    logic       frame_err_a, frame_err_b, frame_err_c;
    logic       busy_a, busy_b, busy_c;

    int errors = 0;
    int checks = 0;
    int ncnt = 0;
    int dcnt_a = 0, dcnt_b = 0, dcnt_c = 0;
    int done_n_a = 0;
    logic err_c = 1'b0;
    logic [6:0] q_c[$];

    uart_rx_param u_a (
        .clk(clk), .reset(reset), .rx(rx_a), .br_tick(br_tick),
        .rx_data(rx_data_a), .rx_done(rx_done_a), .parity_err(parity_err_a),
        .frame_err(frame_err_a), .busy(busy_a));

    uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
        .clk(clk), .reset(reset), .rx(rx_b), .br_tick(br_tick),
        .rx_data(rx_data_b), .rx_done(rx_done_b), .parity_err(parity_err_b),
        .frame_err(frame_err_b), .busy(busy_b));

    uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_c (
        .clk(clk), .reset(reset), .rx(rx_c), .br_tick(br_tick),
        .rx_data(rx_data_c), .rx_done(rx_done_c), .parity_err(parity_err_c),
        .frame_err(frame_err_c), .busy(busy_c));

    always #5 clk = ~clk;

    initial begin
        int ph = 0;
        forever begin
            @(negedge clk);
            br_tick = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    always @(negedge clk) begin
        ncnt++;
        if (rx_done_a === 1'b1) begin dcnt_a++; done_n_a = ncnt; end
        if (rx_done_b === 1'b1) dcnt_b++;
        if (rx_done_c === 1'b1) begin
            dcnt_c++;
            q_c.push_back(rx_data_c);
            if (parity_err_c || frame_err_c) err_c = 1'b1;
        end
    end

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic align_tick(output int start_n);
        @(posedge clk);
        while (br_tick !== 1'b1) @(posedge clk);
        start_n = ncnt;
    endtask

    // Bit i occupies 64 clocks; an optional 4-clock low pulse is forced at offset gofs of bit gbit.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n,
                             input int gbit, input int gofs, output int start_n);
        logic v;
        align_tick(start_n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 64; j++) begin
                @(negedge clk);
                v = bits[4'(i)];
                if (i == gbit && j >= gofs && j < gofs + 4) v = 1'b0;
                set_rx(sel, v);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_data_a !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data_a); end
        checks++; if (rx_done_a !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b want 0", rx_done_a); end
        checks++; if (parity_err_a !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err_a); end
        checks++; if (frame_err_a !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err_a); end
        checks++; if ({busy_a, busy_b, busy_c} !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b want 000", {busy_a, busy_b, busy_c}); end
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (busy_a !== 1'b0 || rx_done_a !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy=%b done=%b want 0 0", busy_a, rx_done_a); end
    endtask

    task automatic test_basic();
        int c0, sn;
        c0 = dcnt_a;
        send_bits(0, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10, -1, 0, sn);
        @(negedge clk);
        checks++; if (dcnt_a !== c0 + 1) begin errors++; $display("FAIL basic_done_count: got %0d want %0d", dcnt_a - c0, 1); end
        checks++; if (rx_data_a !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", rx_data_a); end
        checks++; if (parity_err_a !== 1'b0 || frame_err_a !== 1'b0) begin errors++; $display("FAIL basic_flags: perr=%b ferr=%b want 0 0", parity_err_a, frame_err_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy_a); end
        // Start seen at tick 4, mid-start at tick 36, stop sample at tick 612; done the next clock.
        checks++; if (done_n_a - sn !== 613) begin errors++; $display("FAIL basic_latency: got %0d want 613", done_n_a - sn); end
    endtask

    task automatic test_glitch();
        int c0, sn;
        c0 = dcnt_a;
        align_tick(sn);
        @(negedge clk); rx_a = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1", busy_a); end
        @(negedge clk); rx_a = 1'b1;
        repeat (36) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b want 0", busy_a); end
        checks++; if (dcnt_a !== c0) begin errors++; $display("FAIL glitch_no_done: got %0d pulses want 0", dcnt_a - c0); end
        checks++; if (rx_data_a !== 8'hA5) begin errors++; $display("FAIL glitch_data_held: got %h want a5", rx_data_a); end
    endtask

    task automatic test_framing();
        int c0, sn;
        c0 = dcnt_a;
        send_bits(0, {6'h00, 1'b0, 8'h3C, 1'b0}, 10, -1, 0, sn);
        repeat (192) @(negedge clk);
        checks++; if (dcnt_a !== c0 + 1) begin errors++; $display("FAIL ferr_done_count: got %0d want 1", dcnt_a - c0); end
        checks++; if (rx_data_a !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h want 3c", rx_data_a); end
        checks++; if (frame_err_a !== 1'b1 || parity_err_a !== 1'b0) begin errors++; $display("FAIL ferr_flags: ferr=%b perr=%b want 1 0", frame_err_a, parity_err_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL break_busy: got %b want 0", busy_a); end
        @(negedge clk); rx_a = 1'b1;
        repeat (64) @(negedge clk);
        checks++; if (dcnt_a !== c0 + 1 || busy_a !== 1'b0) begin errors++; $display("FAIL break_no_restart: pulses=%0d busy=%b want 1 0", dcnt_a - c0, busy_a); end
    endtask

    task automatic test_parity();
        int c0, sn;
        c0 = dcnt_b;
        send_bits(1, {5'h1F, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 0, sn);
        @(negedge clk);
        checks++; if (dcnt_b !== c0 + 1) begin errors++; $display("FAIL par_done_count: got %0d want 1", dcnt_b - c0); end
        checks++; if (rx_data_b !== 8'h07) begin errors++; $display("FAIL par_data: got %h want 07", rx_data_b); end
        checks++; if (parity_err_b !== 1'b1 || frame_err_b !== 1'b0) begin errors++; $display("FAIL par_bad: perr=%b ferr=%b want 1 0", parity_err_b, frame_err_b); end
        send_bits(1, {5'h1F, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 0, sn);
        @(negedge clk);
        checks++; if (dcnt_b !== c0 + 2) begin errors++; $display("FAIL par_done_count2: got %0d want 2", dcnt_b - c0); end
        checks++; if (parity_err_b !== 1'b0) begin errors++; $display("FAIL par_good: perr=%b want 0", parity_err_b); end
    endtask

    task automatic test_back_to_back();
        int c0, sn;
        c0 = dcnt_c;
        q_c.delete();
        err_c = 1'b0;
        send_bits(2, {6'h3F, 2'b11, 7'h55, 1'b0}, 10, -1, 0, sn);
        send_bits(2, {6'h3F, 2'b11, 7'h2A, 1'b0}, 10, -1, 0, sn);
        @(negedge clk);
        checks++; if (dcnt_c !== c0 + 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", dcnt_c - c0); end
        checks++; if (q_c.size() < 2 || q_c[0] !== 7'h55) begin errors++; $display("FAIL b2b_first: got %h want 55", (q_c.size() > 0) ? q_c[0] : 7'h7F); end
        checks++; if (q_c.size() < 2 || q_c[1] !== 7'h2A) begin errors++; $display("FAIL b2b_second: got %h want 2a", (q_c.size() > 1) ? q_c[1] : 7'h7F); end
        checks++; if (err_c !== 1'b0) begin errors++; $display("FAIL b2b_errors: got %b want 0", err_c); end
    endtask

    task automatic test_reset_mid();
        int c0, sn;
        c0 = dcnt_a;
        align_tick(sn);
        @(negedge clk); rx_a = 1'b0;
        repeat (63) @(negedge clk);
        @(negedge clk); rx_a = 1'b1;
        repeat (223) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy_a); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++; if (rx_data_a !== 8'h00 || rx_done_a !== 1'b0) begin errors++; $display("FAIL midrst_outputs: data=%h done=%b want 00 0", rx_data_a, rx_done_a); end
        checks++; if ({parity_err_a, frame_err_a, busy_a} !== 3'b000) begin errors++; $display("FAIL midrst_flags: perr/ferr/busy=%b want 000", {parity_err_a, frame_err_a, busy_a}); end
        @(negedge clk); reset = 1'b0;
        repeat (400) @(negedge clk);
        checks++; if (dcnt_a !== c0 || busy_a !== 1'b0) begin errors++; $display("FAIL midrst_no_done: pulses=%0d busy=%b want 0 0", dcnt_a - c0, busy_a); end
        send_bits(0, {6'h3F, 1'b1, 8'h81, 1'b0}, 10, -1, 0, sn);
        @(negedge clk);
        checks++; if (dcnt_a !== c0 + 1) begin errors++; $display("FAIL midrst_next_count: got %0d want 1", dcnt_a - c0); end
        checks++; if (rx_data_a !== 8'h81 || frame_err_a !== 1'b0) begin errors++; $display("FAIL midrst_next_data: data=%h ferr=%b want 81 0", rx_data_a, frame_err_a); end
    endtask

    task automatic test_majority();
        int c0, sn;
        c0 = dcnt_a;
        // Offset 34 of data bit 2 lands the low pulse on exactly the sampling tick.
        send_bits(0, {6'h3F, 1'b1, 8'hFF, 1'b0}, 10, 3, 34, sn);
        @(negedge clk);
        checks++; if (dcnt_a !== c0 + 1) begin errors++; $display("FAIL maj_done_count: got %0d want 1", dcnt_a - c0); end
        checks++; if (rx_data_a !== 8'hFF) begin errors++; $display("FAIL maj_data: got %h want ff", rx_data_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_majority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
